// File: rtl/remote_throw_rx.sv
// Receiver for a throw started on the opponent's board: synchronizes the
// asynchronous flag/power lines, waits for power to settle, and tracks the throw.
module remote_throw_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 60_000_000
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       in_throw_flag,
    input  logic [4:0] in_power,
    input  logic       enable,
    output logic       remote_throw_start,
    output logic [4:0] remote_power,
    output logic       remote_throw_active,
    output logic       remote_throw_done,
    output logic       protocol_error
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, WAIT_LOW} state_t;

    typedef struct packed {
        logic start;
        logic done;
        logic error;
    } events_t;

    logic [SYNC_STAGES-1:0]      flag_sync;
    logic [SYNC_STAGES-1:0][4:0] power_sync;
    logic                        flag_s;
    logic [4:0]                  power_s;
    logic                        flag_d;
    logic                        rise;
    logic                        fall;

    state_t        state_q, state_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [4:0]    sample_q, sample_d;
    events_t       evt_q, evt_d;

    logic       start_o, active_o, done_o, error_o;
    logic [4:0] power_o;

    // The flag stages preset high so a flag already up at reset release is not a rise.
    always_ff @(posedge clk60MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of its neighbours, exactly like real flops.
        if (rst) begin
            flag_sync  <= '1;
            power_sync <= '0;
            flag_d     <= 1'b1;
        end else begin
            flag_sync  <= {flag_sync[SYNC_STAGES-2:0], in_throw_flag};
            power_sync <= {power_sync[SYNC_STAGES-2:0], in_power};
            flag_d     <= flag_s;
        end
    end

    assign flag_s  = flag_sync[SYNC_STAGES-1];
    assign power_s = power_sync[SYNC_STAGES-1];
    assign rise    = flag_s & ~flag_d;
    assign fall    = ~flag_s & flag_d;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q   <= IDLE;
            stable_q  <= '0;
            timeout_q <= '0;
            sample_q  <= '0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            timeout_q <= timeout_d;
            sample_q  <= sample_d;
            evt_q     <= evt_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        stable_d  = stable_q;
        timeout_d = timeout_q;
        sample_d  = sample_q;
        evt_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (rise && enable) begin
                    sample_d = power_s;
                    stable_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // A flag that drops before power settles is a glitch, even on the capture cycle.
                if (!flag_s) begin
                    evt_d.error = 1'b1;
                    state_d     = IDLE;
                end else if (power_s != sample_q) begin
                    sample_d = power_s;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    evt_d.start = 1'b1;
                    timeout_d   = '0;
                    state_d     = ACTIVE;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (fall) begin
                    evt_d.done = 1'b1;
                    state_d    = IDLE;
                end else if (timeout_q == TIMEOUT_LAST) begin
                    evt_d.error = 1'b1;
                    state_d     = WAIT_LOW;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!flag_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_o  = evt_q.start;
        done_o   = evt_q.done;
        error_o  = evt_q.error;
        active_o = (state_q == ACTIVE);
        power_o  = evt_q.start ? sample_q : remote_power;
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            remote_throw_start  <= 1'b0;
            remote_power        <= 5'd0;
            remote_throw_active <= 1'b0;
            remote_throw_done   <= 1'b0;
            protocol_error      <= 1'b0;
        end else begin
            remote_throw_start  <= start_o;
            remote_power        <= power_o;
            remote_throw_active <= active_o;
            remote_throw_done   <= done_o;
            protocol_error      <= error_o;
        end
    end

endmodule

// File: tb/tb_remote_throw_rx.sv
// Bench for remote_throw_rx: scenario table, corner-case sequences and a
// random run, all compared cycle by cycle against a timestamp-based model.
module tb_remote_throw_rx;

    localparam int SYNC    = 2;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 50;
    localparam int LATENCY = SYNC + STABLE + 1;

    logic       clk60MHz = 1'b0;
    logic       rst = 1'b1;
    logic       in_throw_flag = 1'b0;
    logic [4:0] in_power = 5'd0;
    logic       enable = 1'b0;
    logic       remote_throw_start;
    logic [4:0] remote_power;
    logic       remote_throw_active;
    logic       remote_throw_done;
    logic       protocol_error;

    remote_throw_rx #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk60MHz           (clk60MHz),
        .rst                (rst),
        .in_throw_flag      (in_throw_flag),
        .in_power           (in_power),
        .enable             (enable),
        .remote_throw_start (remote_throw_start),
        .remote_power       (remote_power),
        .remote_throw_active(remote_throw_active),
        .remote_throw_done  (remote_throw_done),
        .protocol_error     (protocol_error)
    );

    always #8 clk60MHz = ~clk60MHz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_start, n_done, n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: tracks throw phases with edge timestamps rather than counters.
    typedef enum int {M_IDLE, M_SETTLE, M_ACTIVE, M_WAIT} mphase_t;
    mphase_t    m_phase;
    logic       fq[$];
    logic [4:0] pq[$];
    logic       m_fd;
    logic [4:0] m_sample;
    int         m_t, m_ref;
    logic       p_start, p_done, p_err;
    logic       e_start, e_done, e_err, e_active;
    logic [4:0] e_power;

    task automatic model_step(input logic f, input logic [4:0] p, input logic e, input logic r);
        logic fs, rs, fl;
        logic [4:0] ps;
        m_t++;
        if (r) begin
            m_phase = M_IDLE;
            fq = {};
            pq = {};
            for (int i = 0; i < SYNC; i++) begin
                fq.push_back(1'b1);
                pq.push_back(5'd0);
            end
            m_fd = 1'b1;
            {p_start, p_done, p_err} = '0;
            {e_start, e_done, e_err, e_active} = '0;
            e_power = 5'd0;
            return;
        end
        fs = fq[SYNC-1];
        ps = pq[SYNC-1];
        rs = fs && !m_fd;
        fl = !fs && m_fd;
        e_start  = p_start;
        e_done   = p_done;
        e_err    = p_err;
        e_active = (m_phase == M_ACTIVE);
        if (p_start) e_power = m_sample;
        {p_start, p_done, p_err} = '0;
        case (m_phase)
            M_IDLE: if (rs && e) begin
                m_phase = M_SETTLE; m_sample = ps; m_ref = m_t;
            end
            M_SETTLE: begin
                if (!fs) begin
                    p_err = 1'b1; m_phase = M_IDLE;
                end else if (ps != m_sample) begin
                    m_sample = ps; m_ref = m_t;
                end else if (m_t - m_ref == STABLE) begin
                    p_start = 1'b1; m_phase = M_ACTIVE; m_ref = m_t;
                end
            end
            M_ACTIVE: begin
                if (fl) begin
                    p_done = 1'b1; m_phase = M_IDLE;
                end else if (m_t - m_ref == TIMEOUT) begin
                    p_err = 1'b1; m_phase = M_WAIT;
                end
            end
            M_WAIT: if (!fs) m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
        m_fd = fs;
        void'(fq.pop_back());
        fq.push_front(f);
        void'(pq.pop_back());
        pq.push_front(p);
    endtask

    // One clock: drive inputs away from the edge, sample 1 time unit after it.
    task automatic cycle(input logic f, input logic [4:0] p, input logic e, input logic r);
        in_throw_flag = f;
        in_power      = p;
        enable        = e;
        rst           = r;
        @(posedge clk60MHz);
        #1;
        cyc++;
        model_step(f, p, e, r);
        check($sformatf("model@%0d", cyc),
              {23'd0, remote_throw_start, remote_throw_done, protocol_error,
               remote_throw_active, remote_power},
              {23'd0, e_start, e_done, e_err, e_active, e_power});
        check($sformatf("exclusive@%0d", cyc),
              {31'd0, $onehot0({remote_throw_start, remote_throw_done, protocol_error})}, 32'd1);
        n_start += int'(remote_throw_start);
        n_done  += int'(remote_throw_done);
        n_err   += int'(protocol_error);
    endtask

    task automatic run_until_start(input logic f, input logic [4:0] p, input int budget,
                                   output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle(f, p, 1'b1, 1'b0);
            if (remote_throw_start) seen = 1'b1;
        end
    endtask

    typedef struct {
        logic       en;
        logic [4:0] power;
        int         hold;
        int         starts;
        int         dones;
        int         errs;
        logic [4:0] power_after;
    } row_t;

    row_t rows[9];

    initial begin
        bit         seen;
        int         ref_edge;
        int         seg;
        logic       rf, re, rr;
        logic [4:0] rp;

        rows[0] = '{1'b1, 5'd19, 40, 1, 1, 0, 5'd19};  // nominal throw
        rows[1] = '{1'b1, 5'd0,  20, 1, 1, 0, 5'd0};   // zero power is valid
        rows[2] = '{1'b1, 5'd31, 20, 1, 1, 0, 5'd31};  // full power
        rows[3] = '{1'b1, 5'd5,  3,  0, 0, 1, 5'd31};  // glitch, power untouched
        rows[4] = '{1'b1, 5'd7,  4,  0, 0, 1, 5'd31};  // one cycle short of capture
        rows[5] = '{1'b1, 5'd7,  5,  1, 1, 0, 5'd7};   // just long enough
        rows[6] = '{1'b0, 5'd9,  20, 0, 0, 0, 5'd7};   // disabled
        rows[7] = '{1'b1, 5'd12, 80, 1, 0, 1, 5'd12};  // timeout
        rows[8] = '{1'b1, 5'd25, 20, 1, 1, 0, 5'd25};  // accepted after timeout

        n_start = 0; n_done = 0; n_err = 0;
        cycle(1'b0, 5'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 1'b0, 1'b1);
        check("reset_outputs",
              {27'd0, remote_throw_start, remote_throw_done, protocol_error,
               remote_throw_active, |remote_power}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 1'b0, 1'b0);

        foreach (rows[i]) begin
            n_start = 0; n_done = 0; n_err = 0;
            for (int k = 0; k < 3; k++) cycle(1'b0, rows[i].power, rows[i].en, 1'b0);
            for (int k = 0; k < rows[i].hold; k++) cycle(1'b1, rows[i].power, rows[i].en, 1'b0);
            for (int k = 0; k < 14; k++) cycle(1'b0, rows[i].power, rows[i].en, 1'b0);
            check($sformatf("row%0d_starts", i), 32'(n_start), 32'(rows[i].starts));
            check($sformatf("row%0d_dones", i), 32'(n_done), 32'(rows[i].dones));
            check($sformatf("row%0d_errors", i), 32'(n_err), 32'(rows[i].errs));
            check($sformatf("row%0d_power", i), {27'd0, remote_power}, {27'd0, rows[i].power_after});
        end

        // Start latency from the first edge that samples the flag high.
        cycle(1'b1, 5'd19, 1'b1, 1'b0);
        ref_edge = cyc;
        run_until_start(1'b1, 5'd19, 20, seen);
        check("latency_nominal", seen ? 32'(cyc - ref_edge) : 32'hFFFF_FFFF, 32'(LATENCY));
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'd19, 1'b1, 1'b0);
        check("active_held", {31'd0, remote_throw_active}, 32'd1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 5'd19, 1'b1, 1'b0);

        // Bouncing power: capture counts only from when 22 has settled.
        n_start = 0;
        for (int k = 0; k < 3; k++) cycle(1'b0, 5'd3, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b1, 5'd3, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b1, 5'd7, 1'b1, 1'b0);
        check("bounce_no_early_start", 32'(n_start), 32'd0);
        cycle(1'b1, 5'd22, 1'b1, 1'b0);
        ref_edge = cyc;
        run_until_start(1'b1, 5'd22, 20, seen);
        check("bounce_latency", seen ? 32'(cyc - ref_edge) : 32'hFFFF_FFFF, 32'(LATENCY));
        check("bounce_power", {27'd0, remote_power}, 32'd22);
        for (int k = 0; k < 10; k++) cycle(1'b0, 5'd22, 1'b1, 1'b0);

        // Rise while disabled, enable while still high: no retrigger.
        n_start = 0;
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'd11, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) cycle(1'b1, 5'd11, 1'b1, 1'b0);
        check("held_high_no_start", 32'(n_start), 32'd0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 5'd11, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) cycle(1'b1, 5'd11, 1'b1, 1'b0);
        check("rearm_start", 32'(n_start), 32'd1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 5'd11, 1'b1, 1'b0);

        // Reset mid-ACTIVE with the flag left high.
        cycle(1'b1, 5'd14, 1'b1, 1'b0);
        run_until_start(1'b1, 5'd14, 20, seen);
        check("pre_reset_start_seen", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'd14, 1'b1, 1'b0);
        cycle(1'b1, 5'd14, 1'b1, 1'b1);
        check("mid_active_reset",
              {23'd0, remote_throw_start, remote_throw_done, protocol_error,
               remote_throw_active, remote_power}, 32'd0);
        n_start = 0; n_done = 0; n_err = 0;
        for (int k = 0; k < 20; k++) cycle(1'b1, 5'd14, 1'b1, 1'b0);
        check("post_reset_pulses", 32'(n_start + n_done + n_err), 32'd0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 5'd14, 1'b1, 1'b0);

        // Random traffic against the model.
        seg = 0; rf = 1'b0; re = 1'b1; rp = 5'd0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                rf  = 1'($urandom_range(0, 1));
                re  = ($urandom_range(0, 3) != 0);
                seg = $urandom_range(1, 70);
            end
            seg--;
            if ($urandom_range(0, 7) == 0) rp = 5'($urandom);
            rr = ($urandom_range(0, 399) == 0);
            cycle(rf, rp, re, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
